// File: rtl/breath_led_axil_regs_if.sv
// AXI4-Lite S0_AXI channel bundle between the interconnect master and the breath-LED register slave.
// Latency: none, wires only.
// Backpressure: carried by the READY/VALID pairs of each channel.
interface breath_led_axil_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  // write address channel
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S0_AXI_AWADDR;
  logic [2:0]                      S0_AXI_AWPROT;
  logic                            S0_AXI_AWVALID;
  logic                            S0_AXI_AWREADY;
  // write data channel
  logic [C_S_AXI_DATA_WIDTH-1:0]   S0_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S0_AXI_WSTRB;
  logic                            S0_AXI_WVALID;
  logic                            S0_AXI_WREADY;
  // write response channel
  logic [1:0]                      S0_AXI_BRESP;
  logic                            S0_AXI_BVALID;
  logic                            S0_AXI_BREADY;
  // read address channel
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S0_AXI_ARADDR;
  logic [2:0]                      S0_AXI_ARPROT;
  logic                            S0_AXI_ARVALID;
  logic                            S0_AXI_ARREADY;
  // read data channel
  logic [C_S_AXI_DATA_WIDTH-1:0]   S0_AXI_RDATA;
  logic [1:0]                      S0_AXI_RRESP;
  logic                            S0_AXI_RVALID;
  logic                            S0_AXI_RREADY;

  modport slave (
    input  S0_AXI_AWADDR, S0_AXI_AWPROT, S0_AXI_AWVALID,
    output S0_AXI_AWREADY,
    input  S0_AXI_WDATA, S0_AXI_WSTRB, S0_AXI_WVALID,
    output S0_AXI_WREADY,
    output S0_AXI_BRESP, S0_AXI_BVALID,
    input  S0_AXI_BREADY,
    input  S0_AXI_ARADDR, S0_AXI_ARPROT, S0_AXI_ARVALID,
    output S0_AXI_ARREADY,
    output S0_AXI_RDATA, S0_AXI_RRESP, S0_AXI_RVALID,
    input  S0_AXI_RREADY
  );

  modport master (
    output S0_AXI_AWADDR, S0_AXI_AWPROT, S0_AXI_AWVALID,
    input  S0_AXI_AWREADY,
    output S0_AXI_WDATA, S0_AXI_WSTRB, S0_AXI_WVALID,
    input  S0_AXI_WREADY,
    input  S0_AXI_BRESP, S0_AXI_BVALID,
    output S0_AXI_BREADY,
    output S0_AXI_ARADDR, S0_AXI_ARPROT, S0_AXI_ARVALID,
    input  S0_AXI_ARREADY,
    input  S0_AXI_RDATA, S0_AXI_RRESP, S0_AXI_RVALID,
    output S0_AXI_RREADY
  );
endinterface

// File: rtl/breath_led_axil_regs.sv
// AXI4-Lite slave with four 32-bit R/W registers driving a triangle-ramped PWM "breathing" LED.
// Latency: READY one cycle after VALID, BVALID/RVALID one cycle after the handshake; led lags pwm_cnt by 1 clock.
// Backpressure: held BVALID/RVALID block new AW+W/AR acceptance until BREADY/RREADY are sampled high.
module breath_led_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int PWM_BITS           = 8
) (
  input  logic                  S0_AXI_ACLK,
  input  logic                  S0_AXI_ARESETN,
  breath_led_axil_regs_if.slave s0_axi,
  output logic                  led
);

  localparam int NB = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
  localparam logic [PWM_BITS-1:0] PWM_MAX_M1 = PWM_MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] PWM_ONE    = PWM_BITS'(1);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // register file: [0]=CTRL, [1]=STEP, [2],[3]=scratch
  logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs_q, regs_d;

  // bus handshake state
  logic                          aw_rdy_q, aw_rdy_d;
  logic                          bvalid_q, bvalid_d;
  logic                          ar_rdy_q, ar_rdy_d;
  logic                          rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q,  rdata_d;

  // breath engine state
  logic [PWM_BITS-1:0] pwm_cnt_q,   pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_q,      duty_d;
  logic [15:0]         presc_cnt_q, presc_cnt_d;
  dir_e                dir_q,       dir_d;
  logic                led_q,       led_d;

  logic       wr_fire;
  logic       rd_fire;
  logic [1:0] wr_idx;
  logic [1:0] rd_idx;
  logic       enable;
  logic [15:0] prescale;
  logic       pwm_wrap;
  logic       unused_ok;

  // AW and W are only ever accepted as a pair, so one ready flop serves both
  assign wr_fire  = aw_rdy_q & s0_axi.S0_AXI_AWVALID & s0_axi.S0_AXI_WVALID;
  assign rd_fire  = ar_rdy_q & s0_axi.S0_AXI_ARVALID;
  assign wr_idx   = s0_axi.S0_AXI_AWADDR[3:2];
  assign rd_idx   = s0_axi.S0_AXI_ARADDR[3:2];
  assign enable   = regs_q[0][0];
  assign prescale = regs_q[1][15:0];
  assign pwm_wrap = (pwm_cnt_q == PWM_MAX);

  // protection bits and the byte offset within a word carry no meaning here
  assign unused_ok = ^{s0_axi.S0_AXI_AWPROT, s0_axi.S0_AXI_ARPROT,
                       s0_axi.S0_AXI_AWADDR, s0_axi.S0_AXI_ARADDR};

  assign s0_axi.S0_AXI_AWREADY = aw_rdy_q;
  assign s0_axi.S0_AXI_WREADY  = aw_rdy_q;
  assign s0_axi.S0_AXI_BVALID  = bvalid_q;
  assign s0_axi.S0_AXI_BRESP   = 2'b00;
  assign s0_axi.S0_AXI_ARREADY = ar_rdy_q;
  assign s0_axi.S0_AXI_RVALID  = rvalid_q;
  assign s0_axi.S0_AXI_RDATA   = rdata_q;
  assign s0_axi.S0_AXI_RRESP   = 2'b00;
  assign led                   = led_q;

  // write channel: one-cycle ready pulse, response held until BREADY
  always_comb begin
    aw_rdy_d = s0_axi.S0_AXI_AWVALID & s0_axi.S0_AXI_WVALID & ~bvalid_q & ~aw_rdy_q;
    bvalid_d = bvalid_q;
    if (bvalid_q && s0_axi.S0_AXI_BREADY) bvalid_d = 1'b0;
    if (wr_fire)                          bvalid_d = 1'b1;
  end

  // register file update with per-byte strobes
  always_comb begin
    regs_d = regs_q;
    if (wr_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (s0_axi.S0_AXI_WSTRB[b]) regs_d[wr_idx][8*b +: 8] = s0_axi.S0_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // read channel: data captured from the pre-write array value in the ARREADY cycle
  always_comb begin
    ar_rdy_d = s0_axi.S0_AXI_ARVALID & ~rvalid_q & ~ar_rdy_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rvalid_q && s0_axi.S0_AXI_RREADY) rvalid_d = 1'b0;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[rd_idx];
    end
  end

  // breath engine: PWM counter, prescaler and up/down duty ramp
  always_comb begin
    pwm_cnt_d   = pwm_cnt_q;
    duty_d      = duty_q;
    presc_cnt_d = presc_cnt_q;
    dir_d       = dir_q;
    led_d       = 1'b0;
    if (!enable) begin
      pwm_cnt_d   = '0;
      duty_d      = '0;
      presc_cnt_d = '0;
      dir_d       = DIR_UP;
    end else begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      led_d     = (pwm_cnt_q < duty_q);
      if (pwm_wrap) begin
        if (presc_cnt_q == prescale) begin
          presc_cnt_d = '0;
          case (dir_q)
            DIR_UP: begin
              // saturating step; turn around on reaching the top
              if (duty_q != PWM_MAX) duty_d = duty_q + 1'b1;
              if (duty_q >= PWM_MAX_M1) dir_d = DIR_DOWN;
            end
            default: begin
              if (duty_q != '0) duty_d = duty_q - 1'b1;
              if (duty_q <= PWM_ONE) dir_d = DIR_UP;
            end
          endcase
        end else begin
          presc_cnt_d = presc_cnt_q + 16'd1;
        end
      end
    end
  end

  // bus-side state registers
  always_ff @(posedge S0_AXI_ACLK or negedge S0_AXI_ARESETN) begin
    if (!S0_AXI_ARESETN) begin
      regs_q   <= '0;
      aw_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
      ar_rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      regs_q   <= regs_d;
      aw_rdy_q <= aw_rdy_d;
      bvalid_q <= bvalid_d;
      ar_rdy_q <= ar_rdy_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // breath engine state registers
  always_ff @(posedge S0_AXI_ACLK or negedge S0_AXI_ARESETN) begin
    if (!S0_AXI_ARESETN) begin
      pwm_cnt_q   <= '0;
      duty_q      <= '0;
      presc_cnt_q <= '0;
      dir_q       <= DIR_UP;
      led_q       <= 1'b0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      duty_q      <= duty_d;
      presc_cnt_q <= presc_cnt_d;
      dir_q       <= dir_d;
      led_q       <= led_d;
    end
  end

endmodule

// File: tb/tb_breath_led_axil_regs.sv
// Bench for breath_led_axil_regs: AXI-Lite register access, strobes, backpressure, breath ramp, reset.
// Latency: checks the one-cycle READY and VALID timing of each channel.
// Backpressure: drives BREADY/RREADY low to hold responses.
module tb_breath_led_axil_regs;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic led;

  always #5 clk = ~clk;

  breath_led_axil_regs_if bus ();

  breath_led_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .PWM_BITS(5)
  ) dut (
    .S0_AXI_ACLK   (clk),
    .S0_AXI_ARESETN(rst_n),
    .s0_axi        (bus.slave),
    .led           (led)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [4];
  logic [31:0] rd_q [$];
  int          burst_q [$];

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output int lat_aw, output int lat_b);
    int n;
    @(negedge clk);
    bus.S0_AXI_AWADDR  = addr;
    bus.S0_AXI_WDATA   = data;
    bus.S0_AXI_WSTRB   = strb;
    bus.S0_AXI_AWVALID = 1'b1;
    bus.S0_AXI_WVALID  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.S0_AXI_AWREADY !== 1'b1 && n < 40);
    lat_aw = n;
    total++;
    if (bus.S0_AXI_AWREADY !== 1'b1 || bus.S0_AXI_WREADY !== 1'b1) begin
      bad++;
      $display("FAIL wr_accept addr=%h awready=%b wready=%b want 1/1", addr,
               bus.S0_AXI_AWREADY, bus.S0_AXI_WREADY);
    end
    for (int b = 0; b < 4; b++) if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
    @(negedge clk);
    bus.S0_AXI_AWVALID = 1'b0;
    bus.S0_AXI_WVALID  = 1'b0;
    n = 0;
    while (bus.S0_AXI_BVALID !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    lat_b = n;
    total++;
    if (bus.S0_AXI_BVALID !== 1'b1 || bus.S0_AXI_BRESP !== 2'b00) begin
      bad++;
      $display("FAIL wr_resp addr=%h bvalid=%b bresp=%b want 1/00", addr,
               bus.S0_AXI_BVALID, bus.S0_AXI_BRESP);
    end
  endtask

  task automatic do_read(input logic [3:0] addr, output int lat_ar, output int lat_r);
    int n;
    logic [31:0] exp;
    rd_q.push_back(model[addr[3:2]]);
    @(negedge clk);
    bus.S0_AXI_ARADDR  = addr;
    bus.S0_AXI_ARVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.S0_AXI_ARREADY !== 1'b1 && n < 40);
    lat_ar = n;
    total++;
    if (bus.S0_AXI_ARREADY !== 1'b1) begin
      bad++;
      $display("FAIL rd_arready addr=%h got=%b want=1", addr, bus.S0_AXI_ARREADY);
    end
    @(negedge clk);
    bus.S0_AXI_ARVALID = 1'b0;
    n = 0;
    while (bus.S0_AXI_RVALID !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    lat_r = n;
    exp = rd_q.pop_front();
    total++;
    if (bus.S0_AXI_RVALID !== 1'b1 || bus.S0_AXI_RDATA !== exp || bus.S0_AXI_RRESP !== 2'b00) begin
      bad++;
      $display("FAIL rd_data addr=%h rvalid=%b rdata=%h rresp=%b want 1/%h/00", addr,
               bus.S0_AXI_RVALID, bus.S0_AXI_RDATA, bus.S0_AXI_RRESP, exp);
    end
  endtask

  task automatic test_reset();
    int la, lr;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.S0_AXI_AWREADY, bus.S0_AXI_WREADY, bus.S0_AXI_BVALID, bus.S0_AXI_BRESP,
         bus.S0_AXI_ARREADY, bus.S0_AXI_RVALID, bus.S0_AXI_RRESP, bus.S0_AXI_RDATA, led} !== '0) begin
      bad++;
      $display("FAIL reset_outputs_during got nonzero rdata=%h led=%b want all 0",
               bus.S0_AXI_RDATA, led);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.S0_AXI_AWREADY, bus.S0_AXI_WREADY, bus.S0_AXI_BVALID, bus.S0_AXI_BRESP,
         bus.S0_AXI_ARREADY, bus.S0_AXI_RVALID, bus.S0_AXI_RRESP, bus.S0_AXI_RDATA, led} !== '0) begin
      bad++;
      $display("FAIL reset_outputs_after got nonzero rdata=%h led=%b want all 0",
               bus.S0_AXI_RDATA, led);
    end
    for (int i = 0; i < 4; i++) do_read(4'(i * 4), la, lr);
  endtask

  task automatic test_seq_access();
    logic [31:0] data [4];
    int la, lb, lr, lrr;
    data[0] = 32'h0101FFFF;
    data[1] = 32'hABCD0001;
    data[2] = 32'hDEAD0011;
    data[3] = 32'hBEEF0011;
    for (int i = 0; i < 4; i++) begin
      do_write(4'(i * 4), data[i], 4'hF, la, lb);
      total++;
      if (la !== 1 || lb !== 0) begin
        bad++;
        $display("FAIL wr_latency reg=%0d aw_lat=%0d b_lat=%0d want 1/0", i, la, lb);
      end
      do_read(4'(i * 4), lr, lrr);
      total++;
      if (lr !== 1 || lrr !== 0) begin
        bad++;
        $display("FAIL rd_latency reg=%0d ar_lat=%0d r_lat=%0d want 1/0", i, lr, lrr);
      end
    end
  endtask

  task automatic test_strobes();
    int la, lb;
    do_write(4'h8, 32'h12345678, 4'b0011, la, lb);
    rd_q.push_back(32'hDEAD5678);
    @(negedge clk);
    bus.S0_AXI_ARADDR  = 4'h8;
    bus.S0_AXI_ARVALID = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.S0_AXI_ARVALID = 1'b0;
    begin
      logic [31:0] exp;
      exp = rd_q.pop_front();
      total++;
      if (bus.S0_AXI_RVALID !== 1'b1 || bus.S0_AXI_RDATA !== exp) begin
        bad++;
        $display("FAIL strobe_merge rvalid=%b rdata=%h want 1/%h", bus.S0_AXI_RVALID,
                 bus.S0_AXI_RDATA, exp);
      end
    end
    // low address bits are ignored by the decode
    do_read(4'hA, la, lb);
    do_read(4'h7, la, lb);
  endtask

  task automatic test_backpressure();
    int la, lb, n;
    bus.S0_AXI_BREADY = 1'b0;
    do_write(4'h8, 32'hCAFE0001, 4'hF, la, lb);
    bus.S0_AXI_AWADDR  = 4'hC;
    bus.S0_AXI_WDATA   = 32'h5A5A0002;
    bus.S0_AXI_WSTRB   = 4'hF;
    bus.S0_AXI_AWVALID = 1'b1;
    bus.S0_AXI_WVALID  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus.S0_AXI_BVALID !== 1'b1 || bus.S0_AXI_AWREADY !== 1'b0 || bus.S0_AXI_WREADY !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d bvalid=%b awready=%b wready=%b want 1/0/0", i,
                 bus.S0_AXI_BVALID, bus.S0_AXI_AWREADY, bus.S0_AXI_WREADY);
      end
    end
    bus.S0_AXI_BREADY = 1'b1;
    @(negedge clk);
    total++;
    if (bus.S0_AXI_BVALID !== 1'b0 || bus.S0_AXI_AWREADY !== 1'b0) begin
      bad++;
      $display("FAIL bp_release bvalid=%b awready=%b want 0/0", bus.S0_AXI_BVALID, bus.S0_AXI_AWREADY);
    end
    n = 0;
    while (bus.S0_AXI_AWREADY !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    total++;
    if (bus.S0_AXI_AWREADY !== 1'b1 || bus.S0_AXI_WREADY !== 1'b1 || n !== 1) begin
      bad++;
      $display("FAIL bp_second_accept awready=%b wready=%b wait=%0d want 1/1/1",
               bus.S0_AXI_AWREADY, bus.S0_AXI_WREADY, n);
    end
    model[3] = 32'h5A5A0002;
    @(negedge clk);
    bus.S0_AXI_AWVALID = 1'b0;
    bus.S0_AXI_WVALID  = 1'b0;
    total++;
    if (bus.S0_AXI_BVALID !== 1'b1) begin
      bad++;
      $display("FAIL bp_second_resp bvalid=%b want 1", bus.S0_AXI_BVALID);
    end
    do_read(4'h8, la, lb);
    do_read(4'hC, la, lb);
  endtask

  task automatic test_split_channels();
    int la, lb;
    @(negedge clk);
    bus.S0_AXI_AWADDR  = 4'h4;
    bus.S0_AXI_WDATA   = 32'h00000003;
    bus.S0_AXI_WSTRB   = 4'hF;
    bus.S0_AXI_AWVALID = 1'b1;
    bus.S0_AXI_WVALID  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.S0_AXI_AWREADY !== 1'b0 || bus.S0_AXI_WREADY !== 1'b0) begin
        bad++;
        $display("FAIL split_lone_aw cyc=%0d awready=%b wready=%b want 0/0", i,
                 bus.S0_AXI_AWREADY, bus.S0_AXI_WREADY);
      end
    end
    bus.S0_AXI_WVALID = 1'b1;
    @(negedge clk);
    total++;
    if (bus.S0_AXI_AWREADY !== 1'b1 || bus.S0_AXI_WREADY !== 1'b1) begin
      bad++;
      $display("FAIL split_pulse awready=%b wready=%b want 1/1", bus.S0_AXI_AWREADY, bus.S0_AXI_WREADY);
    end
    model[1] = 32'h00000003;
    @(negedge clk);
    total++;
    if (bus.S0_AXI_AWREADY !== 1'b0 || bus.S0_AXI_WREADY !== 1'b0 || bus.S0_AXI_BVALID !== 1'b1) begin
      bad++;
      $display("FAIL split_pulse_end awready=%b wready=%b bvalid=%b want 0/0/1",
               bus.S0_AXI_AWREADY, bus.S0_AXI_WREADY, bus.S0_AXI_BVALID);
    end
    bus.S0_AXI_AWVALID = 1'b0;
    bus.S0_AXI_WVALID  = 1'b0;
    do_read(4'h4, la, lb);
  endtask

  task automatic test_concurrent();
    logic [31:0] old;
    int la, lb;
    old = model[3];
    @(negedge clk);
    bus.S0_AXI_AWADDR  = 4'hC;
    bus.S0_AXI_WDATA   = 32'h13579BDF;
    bus.S0_AXI_WSTRB   = 4'hF;
    bus.S0_AXI_AWVALID = 1'b1;
    bus.S0_AXI_WVALID  = 1'b1;
    bus.S0_AXI_ARADDR  = 4'hC;
    bus.S0_AXI_ARVALID = 1'b1;
    @(negedge clk);
    total++;
    if (bus.S0_AXI_AWREADY !== 1'b1 || bus.S0_AXI_ARREADY !== 1'b1) begin
      bad++;
      $display("FAIL conc_ready awready=%b arready=%b want 1/1", bus.S0_AXI_AWREADY, bus.S0_AXI_ARREADY);
    end
    model[3] = 32'h13579BDF;
    @(negedge clk);
    bus.S0_AXI_AWVALID = 1'b0;
    bus.S0_AXI_WVALID  = 1'b0;
    bus.S0_AXI_ARVALID = 1'b0;
    total++;
    if (bus.S0_AXI_RVALID !== 1'b1 || bus.S0_AXI_RDATA !== old || bus.S0_AXI_BVALID !== 1'b1) begin
      bad++;
      $display("FAIL conc_old_value rvalid=%b rdata=%h bvalid=%b want 1/%h/1",
               bus.S0_AXI_RVALID, bus.S0_AXI_RDATA, bus.S0_AXI_BVALID, old);
    end
    do_read(4'hC, la, lb);
  endtask

  task automatic check_bursts(input string name, input int bound);
    int run, cyc, exp;
    run = 0;
    cyc = 0;
    while (burst_q.size() > 0 && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (led === 1'b1) run++;
      else if (run > 0) begin
        exp = burst_q.pop_front();
        total++;
        if (run !== exp) begin
          bad++;
          $display("FAIL %s burst_len got=%0d want=%0d", name, run, exp);
        end
        run = 0;
      end
    end
    if (burst_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s timeout with %0d bursts outstanding", name, burst_q.size());
      burst_q.delete();
    end
  endtask

  task automatic test_breath();
    int la, lb, highs;
    do_write(4'h0, 32'h0, 4'hF, la, lb);
    do_write(4'h4, 32'h0, 4'hF, la, lb);
    for (int k = 1; k <= 31; k++) burst_q.push_back(k);
    for (int k = 30; k >= 1; k--) burst_q.push_back(k);
    for (int k = 1; k <= 5; k++)  burst_q.push_back(k);
    do_write(4'h0, 32'h1, 4'hF, la, lb);
    check_bursts("ramp_p0", 4000);
    do_write(4'h0, 32'h0, 4'hF, la, lb);
    @(negedge clk);
    highs = 0;
    for (int i = 0; i < 64; i++) begin
      if (led !== 1'b0) highs++;
      @(negedge clk);
    end
    total++;
    if (highs !== 0) begin
      bad++;
      $display("FAIL disable_led high_cycles=%0d want=0", highs);
    end
    do_write(4'h4, 32'h1, 4'hF, la, lb);
    burst_q.push_back(1); burst_q.push_back(1);
    burst_q.push_back(2); burst_q.push_back(2);
    burst_q.push_back(3); burst_q.push_back(3);
    do_write(4'h0, 32'h1, 4'hF, la, lb);
    check_bursts("ramp_p1", 1000);
    do_write(4'h0, 32'h0, 4'hF, la, lb);
  endtask

  task automatic test_reset_mid_read();
    int la, lb, n, late;
    bus.S0_AXI_RREADY = 1'b0;
    @(negedge clk);
    bus.S0_AXI_ARADDR  = 4'hC;
    bus.S0_AXI_ARVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.S0_AXI_ARREADY !== 1'b1 && n < 40);
    @(negedge clk);
    bus.S0_AXI_ARVALID = 1'b0;
    total++;
    if (bus.S0_AXI_RVALID !== 1'b1 || bus.S0_AXI_RDATA !== model[3]) begin
      bad++;
      $display("FAIL rst_pre_rvalid rvalid=%b rdata=%h want 1/%h", bus.S0_AXI_RVALID,
               bus.S0_AXI_RDATA, model[3]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.S0_AXI_RVALID !== 1'b0 || bus.S0_AXI_RDATA !== 32'h0) begin
      bad++;
      $display("FAIL rst_async rvalid=%b rdata=%h want 0/00000000", bus.S0_AXI_RVALID, bus.S0_AXI_RDATA);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.S0_AXI_RREADY = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    late = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.S0_AXI_RVALID !== 1'b0 || bus.S0_AXI_BVALID !== 1'b0) late++;
    end
    total++;
    if (late !== 0) begin
      bad++;
      $display("FAIL rst_no_late_resp cycles_with_valid=%0d want=0", late);
    end
    for (int i = 0; i < 4; i++) do_read(4'(i * 4), la, lb);
  endtask

  initial begin
    bus.S0_AXI_AWADDR  = '0;
    bus.S0_AXI_AWPROT  = '0;
    bus.S0_AXI_AWVALID = 1'b0;
    bus.S0_AXI_WDATA   = '0;
    bus.S0_AXI_WSTRB   = '0;
    bus.S0_AXI_WVALID  = 1'b0;
    bus.S0_AXI_BREADY  = 1'b1;
    bus.S0_AXI_ARADDR  = '0;
    bus.S0_AXI_ARPROT  = '0;
    bus.S0_AXI_ARVALID = 1'b0;
    bus.S0_AXI_RREADY  = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;

    test_reset();
    test_seq_access();
    test_strobes();
    test_backpressure();
    test_split_channels();
    test_concurrent();
    test_breath();
    test_reset_mid_read();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
